// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared types for the ID/EX pipeline register.
//   regfilemux_sel_t : writeback source select carried to EX/MEM/WB
//   ex_payload_t     : fixed-width ID/EX register payload (ctrl bundle kept separate)
//   is_load()        : true for writeback sources fed by a memory load
//   X0               : architectural zero register address
package id_ex_stage_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    localparam logic [REG_W-1:0] X0 = 5'd0;

    typedef enum logic [3:0] {
        alu_out  = 4'd0,
        br_en    = 4'd1,
        u_imm    = 4'd2,
        lw       = 4'd3,
        pc_plus4 = 4'd4,
        lb       = 4'd5,
        lbu      = 4'd6,
        lh       = 4'd7,
        lhu      = 4'd8
    } regfilemux_sel_t;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic              load_regfile;
        regfilemux_sel_t   regfile_sel;
        logic [XLEN-1:0]   rs1_out;
        logic [XLEN-1:0]   rs2_out;
        logic [XLEN-1:0]   imm;
    } ex_payload_t;

    // Bubble: nothing valid, nothing written, no source that could match a forward.
    localparam ex_payload_t EX_BUBBLE = '{
        valid:        1'b0,
        pc:           '0,
        rs1:          X0,
        rs2:          X0,
        rd:           X0,
        load_regfile: 1'b0,
        regfile_sel:  alu_out,
        rs1_out:      '0,
        rs2_out:      '0,
        imm:          '0
    };

    function automatic logic is_load(input regfilemux_sel_t sel);
        return (sel == lb) || (sel == lbu) || (sel == lh) || (sel == lhu) || (sel == lw);
    endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: combinational load-use hazard detector.
// Flags when the instruction now in EX is a load whose rd is read by the
// instruction in ID; EX/MEM forwarding cannot cover that case.
//   inputs : ex_valid, ex_load_regfile, ex_regfile_sel, ex_rd,
//            id_valid, id_rs1/id_rs1_used, id_rs2/id_rs2_used
//   output : hz_c (combinational)
module load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic             ex_valid,
    input  logic             ex_load_regfile,
    input  regfilemux_sel_t  ex_regfile_sel,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic             id_rs1_used,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs2_used,
    output logic             hz_c
);

    logic ex_is_load_c;
    logic src_match_c;

    assign ex_is_load_c = ex_valid && ex_load_regfile && is_load(ex_regfile_sel) && (ex_rd != X0);
    assign src_match_c  = (id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd));
    assign hz_c         = ex_is_load_c && id_valid && src_match_c;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall and bubble/flush.
// Optional performance counters are built when ID_EX_PERF_EN is defined.
//   clk, rst           : clock, asynchronous active-high reset
//   id_*               : decoded ID-stage instruction and regfile read data
//   wb_*               : writeback port, bypassed into captured operands
//   mem_stall, flush   : freeze pipeline / kill ID instruction
//   stall_id           : combinational, holds PC and IF/ID
//   ex_*               : registered EX-stage view (1-cycle latency)
//   perf_*_cnt         : saturating bubble counters (ID_EX_PERF_EN only)
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned CTRL_W = 16
`ifdef ID_EX_PERF_EN
    ,
    parameter int unsigned PERF_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_load_regfile,
    input  regfilemux_sel_t   id_regfile_sel,
    input  logic [XLEN-1:0]   id_rs1_out,
    input  logic [XLEN-1:0]   id_rs2_out,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_load_regfile,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              mem_stall,
    input  logic              flush,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [REG_W-1:0]  ex_rs1,
    output logic [REG_W-1:0]  ex_rs2,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_load_regfile,
    output regfilemux_sel_t   ex_regfile_sel,
    output logic [XLEN-1:0]   ex_rs1_out,
    output logic [XLEN-1:0]   ex_rs2_out,
    output logic [XLEN-1:0]   ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl
`ifdef ID_EX_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_loaduse_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

    ex_payload_t       ex_q, ex_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              hz_c;
    logic              byp1_c, byp2_c;

    load_use_detect u_load_use_detect (
        .ex_valid        (ex_q.valid),
        .ex_load_regfile (ex_q.load_regfile),
        .ex_regfile_sel  (ex_q.regfile_sel),
        .ex_rd           (ex_q.rd),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs1_used     (id_rs1_used),
        .id_rs2          (id_rs2),
        .id_rs2_used     (id_rs2_used),
        .hz_c            (hz_c)
    );

    assign stall_id = hz_c || mem_stall;

    // Write-through: the regfile read this cycle misses a same-cycle WB write.
    assign byp1_c = wb_load_regfile && (wb_rd != X0) && (wb_rd == id_rs1);
    assign byp2_c = wb_load_regfile && (wb_rd != X0) && (wb_rd == id_rs2);

    // Next state: hold on mem_stall, bubble on flush/hazard/empty ID, else capture.
    always_comb begin
        ex_d   = ex_q;
        ctrl_d = ctrl_q;
        if (!mem_stall) begin
            if (flush || hz_c || !id_valid) begin
                ex_d   = EX_BUBBLE;
                ctrl_d = '0;
            end else begin
                ex_d.valid        = 1'b1;
                ex_d.pc           = id_pc;
                ex_d.rs1          = id_rs1_used ? id_rs1 : X0;
                ex_d.rs2          = id_rs2_used ? id_rs2 : X0;
                ex_d.rd           = id_load_regfile ? id_rd : X0;
                ex_d.load_regfile = id_load_regfile;
                ex_d.regfile_sel  = id_regfile_sel;
                ex_d.rs1_out      = byp1_c ? wb_data : id_rs1_out;
                ex_d.rs2_out      = byp2_c ? wb_data : id_rs2_out;
                ex_d.imm          = id_imm;
                ctrl_d            = id_ctrl;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q   <= EX_BUBBLE;
            ctrl_q <= '0;
        end else begin
            ex_q   <= ex_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign ex_valid        = ex_q.valid;
    assign ex_pc           = ex_q.pc;
    assign ex_rs1          = ex_q.rs1;
    assign ex_rs2          = ex_q.rs2;
    assign ex_rd           = ex_q.rd;
    assign ex_load_regfile = ex_q.load_regfile;
    assign ex_regfile_sel  = ex_q.regfile_sel;
    assign ex_rs1_out      = ex_q.rs1_out;
    assign ex_rs2_out      = ex_q.rs2_out;
    assign ex_imm          = ex_q.imm;
    assign ex_ctrl         = ctrl_q;

`ifdef ID_EX_PERF_EN
    logic [PERF_W-1:0] loaduse_q, loaduse_d;
    logic [PERF_W-1:0] flushc_q, flushc_d;

    // A flush that coincides with a hazard is counted as a flush bubble.
    always_comb begin
        loaduse_d = loaduse_q;
        flushc_d  = flushc_q;
        if (!mem_stall) begin
            if (flush) begin
                if (flushc_q != '1) flushc_d = flushc_q + PERF_W'(1);
            end else if (hz_c) begin
                if (loaduse_q != '1) loaduse_d = loaduse_q + PERF_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loaduse_q <= '0;
            flushc_q  <= '0;
        end else begin
            loaduse_q <= loaduse_d;
            flushc_q  <= flushc_d;
        end
    end

    assign perf_loaduse_cnt = loaduse_q;
    assign perf_flush_cnt   = flushc_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage. Each step pushes the
// expected EX-register contents, takes one clock edge and pops/compares.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid;
    logic [31:0]     id_pc;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            id_rs1_used, id_rs2_used, id_load_regfile;
    regfilemux_sel_t id_regfile_sel;
    logic [31:0]     id_rs1_out, id_rs2_out, id_imm;
    logic [15:0]     id_ctrl;
    logic            wb_load_regfile;
    logic [4:0]      wb_rd;
    logic [31:0]     wb_data;
    logic            mem_stall, flush;
    logic            stall_id;
    logic            ex_valid;
    logic [31:0]     ex_pc;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic            ex_load_regfile;
    regfilemux_sel_t ex_regfile_sel;
    logic [31:0]     ex_rs1_out, ex_rs2_out, ex_imm;
    logic [15:0]     ex_ctrl;
`ifdef ID_EX_PERF_EN
    logic [31:0]     perf_loaduse_cnt, perf_flush_cnt;
`endif

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_load_regfile(id_load_regfile), .id_regfile_sel(id_regfile_sel),
        .id_rs1_out(id_rs1_out), .id_rs2_out(id_rs2_out), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_load_regfile(wb_load_regfile), .wb_rd(wb_rd), .wb_data(wb_data),
        .mem_stall(mem_stall), .flush(flush), .stall_id(stall_id),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_load_regfile(ex_load_regfile), .ex_regfile_sel(ex_regfile_sel),
        .ex_rs1_out(ex_rs1_out), .ex_rs2_out(ex_rs2_out), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl)
`ifdef ID_EX_PERF_EN
        , .perf_loaduse_cnt(perf_loaduse_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        load;
        logic [3:0]  sel;
        logic [31:0] rs1_out, rs2_out, imm;
        logic [15:0] ctrl;
    } ex_t;

    typedef struct {
        bit    bubble;
        ex_t   v;
        string name;
    } sb_t;

    sb_t sbq[$];
    int  total = 0;
    int  bad   = 0;

    // Snapshot of the DUT; bubble data fields are don't-care and masked out.
    function automatic ex_t obs(input bit bubble);
        ex_t o;
        o.valid   = ex_valid;
        o.pc      = bubble ? 32'd0 : ex_pc;
        o.rs1     = ex_rs1;
        o.rs2     = ex_rs2;
        o.rd      = ex_rd;
        o.load    = ex_load_regfile;
        o.sel     = 4'(ex_regfile_sel);
        o.rs1_out = bubble ? 32'd0 : ex_rs1_out;
        o.rs2_out = bubble ? 32'd0 : ex_rs2_out;
        o.imm     = bubble ? 32'd0 : ex_imm;
        o.ctrl    = ex_ctrl;
        return o;
    endfunction

    // Expected captured instruction; imm/ctrl follow the same derivation as set_id.
    function automatic ex_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic ld, input regfilemux_sel_t sel,
                               input logic [31:0] d1, input logic [31:0] d2);
        ex_t o;
        o.valid = 1'b1; o.pc = pc; o.rs1 = rs1; o.rs2 = rs2; o.rd = rd; o.load = ld;
        o.sel = 4'(sel); o.rs1_out = d1; o.rs2_out = d2; o.imm = pc + 32'd100;
        o.ctrl = pc[15:0] ^ 16'hA5A5;
        return o;
    endfunction

    function automatic sb_t cap(input ex_t v, input string name);
        sb_t s;
        s.bubble = 1'b0; s.v = v; s.name = name;
        return s;
    endfunction

    function automatic sb_t bub(input string name);
        sb_t s;
        s.bubble = 1'b1; s.v = '0; s.name = name;
        return s;
    endfunction

    task automatic clear_in();
        id_valid = 1'b0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_load_regfile = 1'b0;
        id_regfile_sel = alu_out; id_rs1_out = '0; id_rs2_out = '0; id_imm = '0; id_ctrl = '0;
        wb_load_regfile = 1'b0; wb_rd = '0; wb_data = '0; mem_stall = 1'b0; flush = 1'b0;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd, input logic ld,
                          input regfilemux_sel_t sel, input logic [31:0] d1, input logic [31:0] d2);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_load_regfile = ld; id_regfile_sel = sel; id_rs1_out = d1; id_rs2_out = d2;
        id_imm = pc + 32'd100; id_ctrl = pc[15:0] ^ 16'hA5A5;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ex_t got;
        got = obs(1'b0);
        total++;
        if (got !== ex_t'(0)) begin
            bad++; $display("FAIL reset_ex got=%h exp=%h", got, ex_t'(0));
        end
        total++;
        if (stall_id !== 1'b0) begin
            bad++; $display("FAIL reset_stall got=%b exp=0", stall_id);
        end
    endtask

    task automatic test_back_to_back();
        sb_t s; ex_t got; logic exp_stall;
        for (int i = 0; i < 2; i++) begin
            exp_stall = 1'b0;
            case (i)
                0: begin
                    set_id(1, 32'h100, 5'd1, 1, 5'd2, 1, 5'd5, 1, alu_out, 32'h11, 32'h22);
                    sbq.push_back(cap(mk(32'h100, 5'd1, 5'd2, 5'd5, 1, alu_out, 32'h11, 32'h22), "b2b_add_x5"));
                end
                default: begin
                    set_id(1, 32'h104, 5'd5, 1, 5'd3, 1, 5'd6, 1, alu_out, 32'h33, 32'h44);
                    sbq.push_back(cap(mk(32'h104, 5'd5, 5'd3, 5'd6, 1, alu_out, 32'h33, 32'h44), "b2b_add_x6"));
                end
            endcase
            #1;
            total++;
            if (stall_id !== exp_stall) begin
                bad++; $display("FAIL b2b_stall step=%0d got=%b exp=%b", i, stall_id, exp_stall);
            end
            tick();
            s = sbq.pop_front(); got = obs(s.bubble); total++;
            if (got !== s.v) begin
                bad++; $display("FAIL %s got=%h exp=%h", s.name, got, s.v);
            end
        end
    endtask

    task automatic test_load_use();
        sb_t s; ex_t got; logic exp_stall;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin
                    exp_stall = 1'b0;
                    set_id(1, 32'h200, 5'd2, 1, 5'd7, 0, 5'd7, 1, lw, 32'h55, 32'h66);
                    sbq.push_back(cap(mk(32'h200, 5'd2, 5'd0, 5'd7, 1, lw, 32'h55, 32'h66), "lu_lw_x7"));
                end
                1: begin
                    exp_stall = 1'b1;
                    set_id(1, 32'h204, 5'd7, 1, 5'd1, 1, 5'd8, 1, alu_out, 32'h0, 32'h77);
                    sbq.push_back(bub("lu_bubble"));
                end
                default: begin
                    exp_stall = 1'b0;
                    sbq.push_back(cap(mk(32'h204, 5'd7, 5'd1, 5'd8, 1, alu_out, 32'h0, 32'h77), "lu_add_after"));
                end
            endcase
            #1;
            total++;
            if (stall_id !== exp_stall) begin
                bad++; $display("FAIL lu_stall step=%0d got=%b exp=%b", i, stall_id, exp_stall);
            end
            tick();
            s = sbq.pop_front(); got = obs(s.bubble); total++;
            if (got !== s.v) begin
                bad++; $display("FAIL %s got=%h exp=%h", s.name, got, s.v);
            end
        end
    endtask

    task automatic test_x0_and_no_write();
        sb_t s; ex_t got;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin
                    set_id(1, 32'h300, 5'd3, 1, 5'd0, 0, 5'd0, 1, lw, 32'h1, 32'h2);
                    sbq.push_back(cap(mk(32'h300, 5'd3, 5'd0, 5'd0, 1, lw, 32'h1, 32'h2), "x0_lw"));
                end
                1: begin
                    set_id(1, 32'h304, 5'd0, 1, 5'd0, 1, 5'd4, 1, alu_out, 32'h0, 32'h0);
                    sbq.push_back(cap(mk(32'h304, 5'd0, 5'd0, 5'd4, 1, alu_out, 32'h0, 32'h0), "x0_add"));
                end
                2: begin
                    set_id(1, 32'h308, 5'd4, 1, 5'd5, 1, 5'd9, 0, alu_out, 32'h8, 32'h9);
                    sbq.push_back(cap(mk(32'h308, 5'd4, 5'd5, 5'd0, 0, alu_out, 32'h8, 32'h9), "nowrite_rd0"));
                end
                default: begin
                    set_id(0, 32'h30C, 5'd1, 1, 5'd2, 1, 5'd10, 1, alu_out, 32'h3, 32'h4);
                    sbq.push_back(bub("invalid_id_bubble"));
                end
            endcase
            #1;
            total++;
            if (stall_id !== 1'b0) begin
                bad++; $display("FAIL x0_stall step=%0d got=%b exp=0", i, stall_id);
            end
            tick();
            s = sbq.pop_front(); got = obs(s.bubble); total++;
            if (got !== s.v) begin
                bad++; $display("FAIL %s got=%h exp=%h", s.name, got, s.v);
            end
        end
    endtask

    task automatic test_flush();
        sb_t s; ex_t got; logic exp_stall; ex_t held;
        held = mk(32'h404, 5'd1, 5'd2, 5'd11, 1, alu_out, 32'hA, 32'hB);
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin
                    exp_stall = 1'b0; flush = 1'b1; mem_stall = 1'b0;
                    set_id(1, 32'h400, 5'd1, 1, 5'd2, 1, 5'd10, 1, alu_out, 32'h1, 32'h2);
                    sbq.push_back(bub("flush_bubble"));
                end
                1: begin
                    exp_stall = 1'b0; flush = 1'b0;
                    set_id(1, 32'h404, 5'd1, 1, 5'd2, 1, 5'd11, 1, alu_out, 32'hA, 32'hB);
                    sbq.push_back(cap(held, "flush_capture_x11"));
                end
                2, 3, 4: begin
                    exp_stall = 1'b1; flush = 1'b1; mem_stall = 1'b1;
                    set_id(1, 32'h408, 5'd3, 1, 5'd4, 1, 5'd12, 1, alu_out, 32'hC, 32'hD);
                    sbq.push_back(cap(held, "flush_memstall_hold"));
                end
                default: begin
                    exp_stall = 1'b0; flush = 1'b1; mem_stall = 1'b0;
                    sbq.push_back(bub("flush_after_memstall"));
                end
            endcase
            #1;
            total++;
            if (stall_id !== exp_stall) begin
                bad++; $display("FAIL flush_stall step=%0d got=%b exp=%b", i, stall_id, exp_stall);
            end
            tick();
            s = sbq.pop_front(); got = obs(s.bubble); total++;
            if (got !== s.v) begin
                bad++; $display("FAIL %s step=%0d got=%h exp=%h", s.name, i, got, s.v);
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_bypass();
        sb_t s; ex_t got;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin
                    wb_load_regfile = 1'b1; wb_rd = 5'd9; wb_data = 32'hDEADBEEF;
                    set_id(1, 32'h500, 5'd9, 1, 5'd9, 1, 5'd12, 1, alu_out, 32'h0, 32'h0);
                    sbq.push_back(cap(mk(32'h500, 5'd9, 5'd9, 5'd12, 1, alu_out, 32'hDEADBEEF, 32'hDEADBEEF), "bypass_x9"));
                end
                1: begin
                    wb_load_regfile = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEADBEEF;
                    set_id(1, 32'h504, 5'd0, 1, 5'd0, 1, 5'd13, 1, alu_out, 32'h1234, 32'h5678);
                    sbq.push_back(cap(mk(32'h504, 5'd0, 5'd0, 5'd13, 1, alu_out, 32'h1234, 32'h5678), "no_bypass_x0"));
                end
                default: begin
                    wb_load_regfile = 1'b0; wb_rd = 5'd9; wb_data = 32'hDEADBEEF;
                    set_id(1, 32'h508, 5'd9, 1, 5'd3, 1, 5'd14, 1, alu_out, 32'h99, 32'h98);
                    sbq.push_back(cap(mk(32'h508, 5'd9, 5'd3, 5'd14, 1, alu_out, 32'h99, 32'h98), "no_bypass_nowrite"));
                end
            endcase
            tick();
            s = sbq.pop_front(); got = obs(s.bubble); total++;
            if (got !== s.v) begin
                bad++; $display("FAIL %s got=%h exp=%h", s.name, got, s.v);
            end
        end
        wb_load_regfile = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    task automatic test_async_reset();
        sb_t s; ex_t got;
        set_id(1, 32'h600, 5'd2, 1, 5'd7, 0, 5'd7, 1, lw, 32'h55, 32'h66);
        sbq.push_back(cap(mk(32'h600, 5'd2, 5'd0, 5'd7, 1, lw, 32'h55, 32'h66), "ar_lw_x7"));
        tick();
        s = sbq.pop_front(); got = obs(s.bubble); total++;
        if (got !== s.v) begin
            bad++; $display("FAIL %s got=%h exp=%h", s.name, got, s.v);
        end
        set_id(1, 32'h604, 5'd7, 1, 5'd1, 1, 5'd8, 1, alu_out, 32'h0, 32'h77);
        #1;
        total++;
        if (stall_id !== 1'b1) begin
            bad++; $display("FAIL ar_stall_before got=%b exp=1", stall_id);
        end
        #2 rst = 1'b1;
        #1;
        got = obs(1'b0); total++;
        if (got !== ex_t'(0)) begin
            bad++; $display("FAIL ar_ex_zero got=%h exp=%h", got, ex_t'(0));
        end
        total++;
        if (stall_id !== 1'b0) begin
            bad++; $display("FAIL ar_stall_after got=%b exp=0", stall_id);
        end
`ifdef ID_EX_PERF_EN
        total++;
        if (perf_loaduse_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
            bad++; $display("FAIL ar_perf_clear got=%0d/%0d exp=0/0", perf_loaduse_cnt, perf_flush_cnt);
        end
`endif
        #1 rst = 1'b0;
    endtask

`ifdef ID_EX_PERF_EN
    task automatic test_perf();
        for (int k = 0; k < 3; k++) begin
            set_id(1, 32'h700, 5'd2, 1, 5'd0, 0, 5'd7, 1, lw, 32'h1, 32'h2);
            tick();
            set_id(1, 32'h704, 5'd7, 1, 5'd1, 1, 5'd8, 1, alu_out, 32'h3, 32'h4);
            tick();
            tick();
        end
        total++;
        if (perf_loaduse_cnt !== 32'd3 || perf_flush_cnt !== 32'd0) begin
            bad++; $display("FAIL perf_loaduse got=%0d/%0d exp=3/0", perf_loaduse_cnt, perf_flush_cnt);
        end
        flush = 1'b1;
        tick();
        mem_stall = 1'b1;
        tick();
        tick();
        mem_stall = 1'b0; flush = 1'b0;
        total++;
        if (perf_flush_cnt !== 32'd1 || perf_loaduse_cnt !== 32'd3) begin
            bad++; $display("FAIL perf_flush got=%0d/%0d exp=1/3", perf_flush_cnt, perf_loaduse_cnt);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        clear_in();
        #2;
        test_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        test_back_to_back();
        test_load_use();
        test_x0_and_no_write();
        test_flush();
        test_bypass();
        test_async_reset();
`ifdef ID_EX_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
